mac_accum: RTL and testbench

MAC_ACCUM -- requirements
Module: mac_accum

---
 rtl/mac_accum_pkg.sv | 19 +
 rtl/mac_accum.sv | 114 +++++++++++
 tb/tb_mac_accum.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_accum_pkg.sv
// Shared parameters and types for the MAC frame accumulator.
package mac_accum_pkg;

    // Operand width of the upstream multiply-add stage.
    localparam int unsigned WIDTH = 8;

    // Width of the upstream A*B+C result that feeds din.
    localparam int unsigned OUT_WIDTH = 2 * WIDTH;

    // Default number of samples summed per frame (legal range 2..16).
    localparam int unsigned N_SAMPLES_DEFAULT = 4;

    // Frame-level control states.
    typedef enum logic {
        ST_ACCUM = 1'b0,   // collecting samples
        ST_HOLD  = 1'b1    // frame sum pending delivery
    } state_t;

endpackage

// File: rtl/mac_accum.sv
// Frame accumulator: sums N_SAMPLES accepted samples and hands the sum off
// over a valid/ready interface, counting delivered frames modulo 256.
module mac_accum
    import mac_accum_pkg::*;
#(
    parameter int unsigned N_SAMPLES = N_SAMPLES_DEFAULT,
    parameter int unsigned ACC_WIDTH = OUT_WIDTH + $clog2(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OUT_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] sum_out,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [7:0]           frame_cnt
);

    localparam int unsigned CNT_W = $clog2(N_SAMPLES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [ACC_WIDTH-1:0] r_sum_out;
    logic                 r_sum_valid;
    logic [7:0]           r_frame_cnt;

    logic                 w_din_ready;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_handshake;
    logic [ACC_WIDTH-1:0] w_acc_sum;

    // Clear outranks a sample, so a cleared cycle never counts as an acceptance.
    assign w_din_ready = (r_state == ST_ACCUM);
    assign w_accept    = din_valid && w_din_ready && !clear;
    assign w_last      = w_accept && (r_cnt == CNT_W'(N_SAMPLES - 1));
    assign w_handshake = r_sum_valid && sum_ready;
    assign w_acc_sum   = r_acc + ACC_WIDTH'(din);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: last sample enters HOLD, handshake returns to ACCUM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // Datapath: accumulator, sample counter and the pending frame sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            if (w_din_ready && clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_last) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sum_out   <= w_acc_sum;
                r_sum_valid <= 1'b1;
            end else if (w_accept) begin
                r_acc <= w_acc_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_handshake) begin
                r_sum_valid <= 1'b0;
            end
        end
    end

    // Delivered-frame counter, wraps naturally at 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_handshake) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign din_ready = w_din_ready;
    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_mac_accum.sv
// Directed self-checking bench for mac_accum (OUT_WIDTH=16, N_SAMPLES=4).
module tb_mac_accum;

    localparam int unsigned OW = 16;
    localparam int unsigned AW = 18;

    logic          clk;
    logic          rst_n;
    logic [OW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          clear;
    logic [AW-1:0] sum_out;
    logic          sum_valid;
    logic          sum_ready;
    logic [7:0]    frame_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mac_accum #(
        .N_SAMPLES(4),
        .ACC_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .clear     (clear),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .frame_cnt (frame_cnt)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one cycle.
    task automatic send(input logic [OW-1:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Asynchronous assertion, release shortly after a clock edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #2;
        check("rst_sum_out", 32'(sum_out), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_din_ready", 32'(din_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        clear     = 1'b0;
        sum_ready = 1'b0;
        #12;
        check("init_sum_out", 32'(sum_out), 32'd0);
        check("init_sum_valid", 32'(sum_valid), 32'd0);
        check("init_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("init_din_ready", 32'(din_ready), 32'd1);

        // Basic frame 10+20+30+40, downstream always ready.
        sum_ready = 1'b1;
        send(16'd10);
        send(16'd20);
        send(16'd30);
        check("f1_no_early_valid", 32'(sum_valid), 32'd0);
        send(16'd40);
        check("f1_valid", 32'(sum_valid), 32'd1);
        check("f1_sum", 32'(sum_out), 32'd100);
        check("f1_din_ready_hold", 32'(din_ready), 32'd0);
        check("f1_cnt_before", 32'(frame_cnt), 32'd0);
        tick();
        check("f1_valid_drop", 32'(sum_valid), 32'd0);
        check("f1_cnt", 32'(frame_cnt), 32'd1);
        check("f1_din_ready_back", 32'(din_ready), 32'd1);

        // Full-scale samples, no truncation.
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        check("f2_sum", 32'(sum_out), 32'd262140);
        check("f2_valid", 32'(sum_valid), 32'd1);
        tick();
        check("f2_cnt", 32'(frame_cnt), 32'd2);

        // Back-pressure: held result, extra samples ignored.
        sum_ready = 1'b0;
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        din       = 16'd99;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_sum_held", 32'(sum_out), 32'd10);
            check("bp_valid_held", 32'(sum_valid), 32'd1);
            check("bp_din_ready", 32'(din_ready), 32'd0);
        end
        din_valid = 1'b0;
        sum_ready = 1'b1;
        tick();
        check("bp_cnt", 32'(frame_cnt), 32'd3);
        for (int i = 0; i < 4; i++) send(16'd1);
        check("bp_next_sum", 32'(sum_out), 32'd4);
        tick();
        check("bp_next_cnt", 32'(frame_cnt), 32'd4);

        // Clear in ACCUM drops partial frame and the concurrent sample.
        sum_ready = 1'b0;
        send(16'd5);
        send(16'd5);
        clear = 1'b1;
        send(16'd7);
        clear = 1'b0;
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        check("clr_sum", 32'(sum_out), 32'd10);
        check("clr_valid", 32'(sum_valid), 32'd1);
        // Clear during HOLD leaves the pending result alone.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_hold_sum", 32'(sum_out), 32'd10);
        check("clr_hold_valid", 32'(sum_valid), 32'd1);
        sum_ready = 1'b1;
        tick();
        check("clr_hold_cnt", 32'(frame_cnt), 32'd5);

        // Clear on the last sample: no frame produced.
        send(16'd1);
        send(16'd2);
        send(16'd3);
        clear = 1'b1;
        send(16'd4);
        clear = 1'b0;
        check("clr_last_no_valid", 32'(sum_valid), 32'd0);
        check("clr_last_din_ready", 32'(din_ready), 32'd1);
        tick();
        check("idle_ready_no_effect", 32'(frame_cnt), 32'd5);
        for (int i = 0; i < 4; i++) send(16'd1);
        check("clr_last_next_sum", 32'(sum_out), 32'd4);
        tick();
        check("clr_last_cnt", 32'(frame_cnt), 32'd6);

        // Reset mid-frame.
        send(16'd7);
        send(16'd7);
        pulse_reset();
        send(16'd1);
        send(16'd2);
        send(16'd3);
        send(16'd4);
        check("rst_mid_sum", 32'(sum_out), 32'd10);
        tick();
        check("rst_mid_cnt", 32'(frame_cnt), 32'd1);

        // Reset during HOLD.
        sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd5);
        check("rst_hold_pre_sum", 32'(sum_out), 32'd20);
        pulse_reset();
        sum_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'd2);
        check("rst_hold_next_sum", 32'(sum_out), 32'd8);
        tick();
        check("rst_hold_cnt", 32'(frame_cnt), 32'd1);

        // 256 frames from reset: frame_cnt wraps to 0.
        pulse_reset();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 4; i++) send(16'd3);
            tick();
            if (f == 254) check("wrap_255", 32'(frame_cnt), 32'd255);
        end
        check("wrap_0", 32'(frame_cnt), 32'd0);
        check("wrap_last_sum", 32'(sum_out), 32'd12);
        check("wrap_din_ready", 32'(din_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
